// File: rtl/chip_dispense_pkg.sv
// Shared definitions for the multi-channel chip dispenser: FSM state codes,
// channel-index width helper and default servo positions.
package chip_dispense_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREP   = 2'd1;
  localparam logic [1:0] ST_PUSH   = 2'd2;
  localparam logic [1:0] ST_RETURN = 2'd3;

  localparam int unsigned DEF_REST_POS = 375;
  localparam int unsigned DEF_PREP_POS = 375;
  localparam int unsigned DEF_PUSH_POS = 200;

  // max(1, clog2(n)) so a single-channel build still has a 1-bit index
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Phase timer: counts up from zero after a synchronous clear and flags the
// last cycle of a phase whose length is given by limit.
module dispense_timer #(
  parameter int TMR_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [TMR_W-1:0] limit,
  output logic             tc
);

  logic [TMR_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + TMR_W'(1);
    end
  end

  assign tc = (count == limit - TMR_W'(1));

endmodule

// File: rtl/chip_dispense_multi.sv
// N-channel chip dispenser: accepts (channel, count) requests and sequences the
// selected servo through PREP/PUSH/RETURN per chip, with abort and error report.
module chip_dispense_multi
  import chip_dispense_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int POS_W    = 10,
  parameter int TMR_W    = 25,
  parameter int CNT_W    = 4,
  parameter int T_PREP   = 15000000,
  parameter int T_PUSH   = 20000000,
  parameter int T_RETURN = 20000000,
  parameter logic [NUM_CH*POS_W-1:0] REST_POS = {NUM_CH{POS_W'(DEF_REST_POS)}},
  parameter logic [NUM_CH*POS_W-1:0] PREP_POS = {NUM_CH{POS_W'(DEF_PREP_POS)}},
  parameter logic [NUM_CH*POS_W-1:0] PUSH_POS = {NUM_CH{POS_W'(DEF_PUSH_POS)}},
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CH_W-1:0]         req_ch,
  input  logic [CNT_W-1:0]        req_count,
  input  logic                    abort,
  output logic [NUM_CH*POS_W-1:0] servo_pos,
  output logic [NUM_CH-1:0]       ch_led,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        done_count,
  output logic                    err
);

  localparam logic [1:0] FIRST_ST = (T_PREP == 0) ? ST_PUSH : ST_PREP;

  logic [1:0]              state, state_n;
  logic [CH_W-1:0]         ch, ch_n;
  logic [CNT_W-1:0]        remaining, remaining_n;
  logic [CNT_W-1:0]        pushed, pushed_n;
  logic [CNT_W-1:0]        done_count_n;
  logic [NUM_CH-1:0]       ch_led_n;
  logic [NUM_CH*POS_W-1:0] servo_n;
  logic                    done_n, err_n;
  logic                    tmr_clr, tmr_tc;
  logic [TMR_W-1:0]        tmr_limit;
  logic                    accept, bad_req;

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE) && !done;
  assign accept    = req_valid && req_ready;
  assign bad_req   = (32'(req_ch) >= NUM_CH) || (req_count == '0);

  always_comb begin
    case (state)
      ST_PREP:   tmr_limit = TMR_W'(T_PREP);
      ST_PUSH:   tmr_limit = TMR_W'(T_PUSH);
      ST_RETURN: tmr_limit = TMR_W'(T_RETURN);
      default:   tmr_limit = TMR_W'(1);
    endcase
  end

  dispense_timer #(.TMR_W(TMR_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    ch_n         = ch;
    remaining_n  = remaining;
    pushed_n     = pushed;
    done_count_n = done_count;
    ch_led_n     = ch_led;
    done_n       = 1'b0;
    err_n        = 1'b0;
    tmr_clr      = 1'b0;

    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (accept) begin
          if (bad_req) begin
            err_n = 1'b1;
          end else begin
            ch_n        = req_ch;
            remaining_n = req_count;
            pushed_n    = '0;
            ch_led_n    = NUM_CH'(1) << req_ch;
            state_n     = FIRST_ST;
          end
        end
      end
      ST_PREP: begin
        if (abort) begin
          state_n     = ST_RETURN;
          remaining_n = CNT_W'(1);
          tmr_clr     = 1'b1;
        end else if (tmr_tc) begin
          state_n = ST_PUSH;
          tmr_clr = 1'b1;
        end
      end
      ST_PUSH: begin
        if (abort) remaining_n = CNT_W'(1);
        if (tmr_tc) begin
          pushed_n = pushed + CNT_W'(1);
          state_n  = ST_RETURN;
          tmr_clr  = 1'b1;
        end
      end
      default: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (remaining == CNT_W'(1)) begin
            done_n       = 1'b1;
            done_count_n = pushed;
            ch_led_n     = '0;
            state_n      = ST_IDLE;
          end else if (abort) begin
            // abort landing on the exit cycle re-enters RETURN as the final chip
            remaining_n = CNT_W'(1);
            state_n     = ST_RETURN;
          end else begin
            remaining_n = remaining - CNT_W'(1);
            state_n     = FIRST_ST;
          end
        end else if (abort) begin
          remaining_n = CNT_W'(1);
        end
      end
    endcase
  end

  // Registered servo bus follows the next state so each position appears on
  // the first cycle of its phase.
  always_comb begin
    servo_n = REST_POS;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(ch_n) == i) begin
        if (state_n == ST_PREP) begin
          servo_n[i*POS_W +: POS_W] = PREP_POS[i*POS_W +: POS_W];
        end else if (state_n == ST_PUSH) begin
          servo_n[i*POS_W +: POS_W] = PUSH_POS[i*POS_W +: POS_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch         <= '0;
      remaining  <= '0;
      pushed     <= '0;
      done_count <= '0;
      ch_led     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      servo_pos  <= REST_POS;
    end else begin
      state      <= state_n;
      ch         <= ch_n;
      remaining  <= remaining_n;
      pushed     <= pushed_n;
      done_count <= done_count_n;
      ch_led     <= ch_led_n;
      done       <= done_n;
      err        <= err_n;
      servo_pos  <= servo_n;
    end
  end

endmodule
